// File: rtl/sa_pkg.sv
// Shared types and helpers for the streaming systolic matrix-multiply array.
package sa_pkg;

    typedef enum logic [1:0] {
        SA_IDLE,
        SA_FEED,
        SA_FLUSH,
        SA_DRAIN
    } sa_state_e;

    // Counter width for a count range of n values; never narrower than one bit.
    function automatic int unsigned sa_cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Round half-up at bit frac, then saturate to a signed d_w-bit range.
    function automatic logic signed [31:0] sa_requant(
        input logic signed [63:0] acc,
        input int unsigned        frac,
        input int unsigned        d_w
    );
        logic signed [63:0] rnd;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi  = (64'sd1 <<< (d_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (d_w - 1));
        rnd = (frac == 0) ? acc : ((acc + (64'sd1 <<< (frac - 1))) >>> frac);
        if (rnd > hi) begin
            rnd = hi;
        end else if (rnd < lo) begin
            rnd = lo;
        end
        return 32'(rnd);
    endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// One output-stationary PE: forwards tagged x/w one hop and accumulates x*w on tagged beats.
module sa_mac_pe
    import sa_pkg::*;
#(
    parameter int unsigned D_W   = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_CLR,
    input  logic [D_W-1:0]   I_X,
    input  logic             I_X_TAG,
    input  logic [D_W-1:0]   I_W,
    input  logic             I_W_TAG,
    output logic [D_W-1:0]   O_X,
    output logic             O_X_TAG,
    output logic [D_W-1:0]   O_W,
    output logic             O_W_TAG,
    output logic [ACC_W-1:0] O_ACC
);

    logic signed [2*D_W-1:0] prod_c;
    logic [D_W-1:0]          x_q;
    logic [D_W-1:0]          w_q;
    logic                    xt_q;
    logic                    wt_q;
    logic [ACC_W-1:0]        acc_q;

    assign prod_c = $signed(I_X) * $signed(I_W);

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            x_q   <= '0;
            w_q   <= '0;
            xt_q  <= 1'b0;
            wt_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            x_q  <= I_X;
            w_q  <= I_W;
            xt_q <= I_X_TAG;
            wt_q <= I_W_TAG;
            if (I_CLR) begin
                acc_q <= '0;
            end else if (I_X_TAG && I_W_TAG) begin
                acc_q <= acc_q + ACC_W'(prod_c);
            end
        end
    end

    assign O_X     = x_q;
    assign O_X_TAG = xt_q;
    assign O_W     = w_q;
    assign O_W_TAG = wt_q;
    assign O_ACC   = acc_q;

endmodule

// File: rtl/sa_stream_array.sv
// Streaming SA_R x SA_C systolic matmul: skewed operand feed, output-stationary PEs,
// requantised row-by-row drain with valid/ready on both sides.
module sa_stream_array
    import sa_pkg::*;
#(
    parameter int unsigned D_W   = 8,
    parameter int unsigned FRAC  = 5,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SA_R  = 16,
    parameter int unsigned SA_C  = 16,
    parameter int unsigned K_MAX = 64,
    localparam int unsigned KL_W  = $clog2(K_MAX + 1),
    localparam int unsigned IDX_W = sa_cnt_w(SA_R)
) (
    input  logic                       I_CLK,
    input  logic                       I_RST,
    input  logic                       I_START,
    input  logic [KL_W-1:0]            I_K_LEN,
    input  logic                       I_ACC_MODE,
    input  logic                       I_IN_VLD,
    output logic                       O_IN_RDY,
    input  logic [0:SA_R-1][D_W-1:0]   I_X_COL,
    input  logic [0:SA_C-1][D_W-1:0]   I_W_ROW,
    output logic                       O_OUT_VLD,
    input  logic                       I_OUT_RDY,
    output logic [0:SA_C-1][D_W-1:0]   O_OUT_ROW,
    output logic [IDX_W-1:0]           O_OUT_IDX,
    output logic                       O_BUSY,
    output logic                       O_DONE,
    output logic                       O_ERR
);

    localparam int unsigned FL_W = sa_cnt_w(SA_R + SA_C - 1);

    sa_state_e                  state;
    logic [KL_W-1:0]            k_len;
    logic [KL_W-1:0]            bt_cnt;
    logic [FL_W-1:0]            fl_cnt;
    logic                       in_rdy;
    logic                       out_vld;
    logic [0:SA_C-1][D_W-1:0]   out_row;
    logic [IDX_W-1:0]           out_idx;
    logic                       busy;
    logic                       done;
    logic                       err;

    logic                       len_ok_c;
    logic                       beat_acc_c;
    logic                       clr_c;
    logic [IDX_W-1:0]           row_sel_c;
    logic [0:SA_C-1][D_W-1:0]   req_row_c;

    logic [D_W-1:0]   x_sk   [0:SA_R-1];
    logic             x_sk_t [0:SA_R-1];
    logic [D_W-1:0]   w_sk   [0:SA_C-1];
    logic             w_sk_t [0:SA_C-1];
    logic [D_W-1:0]   x_o    [0:SA_R-1][0:SA_C-1];
    logic             xt_o   [0:SA_R-1][0:SA_C-1];
    logic [D_W-1:0]   w_o    [0:SA_R-1][0:SA_C-1];
    logic             wt_o   [0:SA_R-1][0:SA_C-1];
    logic [ACC_W-1:0] acc_m  [0:SA_R-1][0:SA_C-1];

    assign len_ok_c   = (I_K_LEN != '0) && (I_K_LEN <= KL_W'(K_MAX));
    assign beat_acc_c = (state == SA_FEED) && in_rdy && I_IN_VLD;
    assign clr_c      = (state == SA_IDLE) && I_START && len_ok_c && !I_ACC_MODE;

    // Row i of X gets i+1 register stages so it meets column k of W on the diagonal.
    for (genvar i = 0; i < SA_R; i++) begin : g_xsk
        logic [D_W-1:0] dat [0:i];
        logic           tag [0:i];
        always_ff @(posedge I_CLK or posedge I_RST) begin
            if (I_RST) begin
                for (int s = 0; s <= i; s++) begin
                    dat[s] <= '0;
                    tag[s] <= 1'b0;
                end
            end else begin
                dat[0] <= beat_acc_c ? I_X_COL[i] : '0;
                tag[0] <= beat_acc_c;
                for (int s = 1; s <= i; s++) begin
                    dat[s] <= dat[s-1];
                    tag[s] <= tag[s-1];
                end
            end
        end
        assign x_sk[i]   = dat[i];
        assign x_sk_t[i] = tag[i];
    end

    for (genvar j = 0; j < SA_C; j++) begin : g_wsk
        logic [D_W-1:0] dat [0:j];
        logic           tag [0:j];
        always_ff @(posedge I_CLK or posedge I_RST) begin
            if (I_RST) begin
                for (int s = 0; s <= j; s++) begin
                    dat[s] <= '0;
                    tag[s] <= 1'b0;
                end
            end else begin
                dat[0] <= beat_acc_c ? I_W_ROW[j] : '0;
                tag[0] <= beat_acc_c;
                for (int s = 1; s <= j; s++) begin
                    dat[s] <= dat[s-1];
                    tag[s] <= tag[s-1];
                end
            end
        end
        assign w_sk[j]   = dat[j];
        assign w_sk_t[j] = tag[j];
    end

    for (genvar i = 0; i < SA_R; i++) begin : g_row
        for (genvar j = 0; j < SA_C; j++) begin : g_col
            logic [D_W-1:0] x_in;
            logic           xt_in;
            logic [D_W-1:0] w_in;
            logic           wt_in;
            if (j == 0) begin : g_xe
                assign x_in  = x_sk[i];
                assign xt_in = x_sk_t[i];
            end else begin : g_xi
                assign x_in  = x_o[i][j-1];
                assign xt_in = xt_o[i][j-1];
            end
            if (i == 0) begin : g_we
                assign w_in  = w_sk[j];
                assign wt_in = w_sk_t[j];
            end else begin : g_wi
                assign w_in  = w_o[i-1][j];
                assign wt_in = wt_o[i-1][j];
            end
            sa_mac_pe #(
                .D_W   (D_W),
                .ACC_W (ACC_W)
            ) u_pe (
                .I_CLK   (I_CLK),
                .I_RST   (I_RST),
                .I_CLR   (clr_c),
                .I_X     (x_in),
                .I_X_TAG (xt_in),
                .I_W     (w_in),
                .I_W_TAG (wt_in),
                .O_X     (x_o[i][j]),
                .O_X_TAG (xt_o[i][j]),
                .O_W     (w_o[i][j]),
                .O_W_TAG (wt_o[i][j]),
                .O_ACC   (acc_m[i][j])
            );
        end
    end

    // Drain mux: the row to be presented after the next load (row 0 on entry, else r+1).
    always_comb begin
        row_sel_c = '0;
        if ((state == SA_DRAIN) && (out_idx != IDX_W'(SA_R - 1))) begin
            row_sel_c = out_idx + IDX_W'(1);
        end
        for (int j = 0; j < SA_C; j++) begin
            req_row_c[j] = D_W'(sa_requant(
                {{(64 - ACC_W){acc_m[row_sel_c][j][ACC_W-1]}}, acc_m[row_sel_c][j]},
                FRAC, D_W));
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state   <= SA_IDLE;
            k_len   <= '0;
            bt_cnt  <= '0;
            fl_cnt  <= '0;
            in_rdy  <= 1'b0;
            out_vld <= 1'b0;
            out_row <= '0;
            out_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                SA_IDLE: begin
                    if (I_START) begin
                        if (len_ok_c) begin
                            k_len  <= I_K_LEN;
                            bt_cnt <= '0;
                            in_rdy <= 1'b1;
                            busy   <= 1'b1;
                            state  <= SA_FEED;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SA_FEED: begin
                    if (beat_acc_c) begin
                        if ((bt_cnt + KL_W'(1)) == k_len) begin
                            in_rdy <= 1'b0;
                            fl_cnt <= '0;
                            state  <= SA_FLUSH;
                        end else begin
                            bt_cnt <= bt_cnt + KL_W'(1);
                        end
                    end
                end
                // Wait out the skew so the last beat reaches PE(SA_R-1,SA_C-1).
                SA_FLUSH: begin
                    if (fl_cnt == FL_W'(SA_R + SA_C - 2)) begin
                        out_vld <= 1'b1;
                        out_idx <= '0;
                        out_row <= req_row_c;
                        state   <= SA_DRAIN;
                    end else begin
                        fl_cnt <= fl_cnt + FL_W'(1);
                    end
                end
                SA_DRAIN: begin
                    if (out_vld && I_OUT_RDY) begin
                        if (out_idx == IDX_W'(SA_R - 1)) begin
                            out_vld <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= SA_IDLE;
                        end else begin
                            out_idx <= out_idx + IDX_W'(1);
                            out_row <= req_row_c;
                        end
                    end
                end
                default: state <= SA_IDLE;
            endcase
        end
    end

    assign O_IN_RDY  = in_rdy;
    assign O_OUT_VLD = out_vld;
    assign O_OUT_ROW = out_row;
    assign O_OUT_IDX = out_idx;
    assign O_BUSY    = busy;
    assign O_DONE    = done;
    assign O_ERR     = err;

endmodule

// File: tb/tb_sa_stream_array.sv
// Directed bench for sa_stream_array on a 4x4 array: vector table plus corner sequences.
module tb_sa_stream_array;
    import sa_pkg::*;

    localparam int R = 4;
    localparam int C = 4;
    localparam int LAT = R + C - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [6:0]        k_len;
    logic              acc_mode;
    logic              in_vld;
    logic              in_rdy;
    logic [0:R-1][7:0] x_col;
    logic [0:C-1][7:0] w_row;
    logic              out_vld;
    logic              out_rdy;
    logic [0:C-1][7:0] out_row;
    logic [1:0]        out_idx;
    logic              busy;
    logic              done;
    logic              err;

    int n_chk = 0;
    int n_fail = 0;
    int xs [0:63][0:R-1];
    int ws [0:63][0:C-1];
    logic [31:0] got [0:R-1];

    typedef struct {
        int kind;   // 0: uniform operands, all outputs = ev; 1: identity X, W(k,j)=k+j
        int kl;
        int xv;
        int wv;
        bit vtog;
        bit rrnd;
        int ev;
    } vec_t;

    vec_t tbl [0:8];

    always #5 clk = ~clk;

    sa_stream_array #(
        .D_W(8), .FRAC(5), .ACC_W(24), .SA_R(R), .SA_C(C), .K_MAX(64)
    ) dut (
        .I_CLK(clk), .I_RST(rst), .I_START(start), .I_K_LEN(k_len),
        .I_ACC_MODE(acc_mode), .I_IN_VLD(in_vld), .O_IN_RDY(in_rdy),
        .I_X_COL(x_col), .I_W_ROW(w_row), .O_OUT_VLD(out_vld),
        .I_OUT_RDY(out_rdy), .O_OUT_ROW(out_row), .O_OUT_IDX(out_idx),
        .O_BUSY(busy), .O_DONE(done), .O_ERR(err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [38:0] all_out();
        return {in_rdy, out_vld, busy, done, err, out_idx, out_row};
    endfunction

    task automatic load_uniform(input int xv, input int wv, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < R; i++) xs[k][i] = xv;
            for (int j = 0; j < C; j++) ws[k][j] = wv;
        end
    endtask

    task automatic load_ident();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < R; i++) xs[k][i] = (i == k) ? 32 : 0;
            for (int j = 0; j < C; j++) ws[k][j] = k + j;
        end
    endtask

    task automatic load_mix();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < R; i++) xs[k][i] = 8 * i - 3 * k + 5;
            for (int j = 0; j < C; j++) ws[k][j] = 5 * j - 7 * k + 2;
        end
    endtask

    // Reference: sum over k in [k0,k1), round half-up at bit 5, saturate to int8.
    function automatic logic [31:0] model_row(input int r, input int k0, input int k1);
        logic [0:C-1][7:0] row;
        for (int j = 0; j < C; j++) begin
            int s;
            s = 0;
            for (int k = k0; k < k1; k++) s += xs[k][r] * ws[k][j];
            s = (s + 16) >>> 5;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            row[j] = 8'(s);
        end
        return row;
    endfunction

    task automatic start_feed(input int kl, input bit am, input int koff, input bit vtog, input bit spur);
        int  beats;
        int  cyc;
        bit  acc_now;
        bit  err_seen;
        @(negedge clk);
        start = 1'b1;
        k_len = 7'(kl);
        acc_mode = am;
        @(negedge clk);
        start = spur;
        k_len = '0;
        beats = 0;
        cyc = 0;
        err_seen = 1'b0;
        while (beats < kl && cyc < 1000) begin
            in_vld = vtog ? (cyc % 2 == 0) : 1'b1;
            for (int i = 0; i < R; i++) x_col[i] = in_vld ? 8'(xs[koff + beats][i]) : 8'($urandom);
            for (int j = 0; j < C; j++) w_row[j] = in_vld ? 8'(ws[koff + beats][j]) : 8'($urandom);
            acc_now = in_vld && in_rdy;
            @(negedge clk);
            if (err) err_seen = 1'b1;
            if (acc_now) beats++;
            cyc++;
        end
        in_vld = 1'b0;
        start = 1'b0;
        chk("beats_accepted", kl, 64'(beats), 64'(kl));
        if (!vtog) chk("feed_cycles", kl, 64'(cyc), 64'(kl));
        if (spur) chk("busy_start_no_err", 0, 64'(err_seen), 64'd0);
    endtask

    task automatic drain(input bit rrnd);
        int   lat;
        int   nrow;
        int   cyc;
        bit   holding;
        bit   rdy_now;
        logic [31:0] held;
        lat = 0;
        while (!out_vld && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("first_vld_latency", 0, 64'(lat), 64'(LAT));
        nrow = 0;
        cyc = 0;
        holding = 1'b0;
        held = '0;
        while (nrow < R && cyc < 500) begin
            rdy_now = rrnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_rdy = rdy_now;
            if (out_vld) begin
                if (holding) chk("row_held_stable", nrow, 64'({out_idx, out_row}), 64'({2'(nrow), held}));
                if (rdy_now) begin
                    chk("row_index", nrow, 64'(out_idx), 64'(nrow));
                    got[nrow] = out_row;
                    nrow++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held = out_row;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_rdy = 1'b0;
        chk("rows_accepted", 0, 64'(nrow), 64'(R));
        chk("done_pulse_busy_vld", 0, 64'({done, busy, out_vld}), 64'b100);
        @(negedge clk);
        chk("done_clears", 0, 64'({done, busy, out_vld}), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        k_len = '0;
        acc_mode = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b0;
        x_col = '0;
        w_row = '0;

        tbl[0] = '{kind: 1, kl: 4,  xv: 0,   wv: 0,    vtog: 0, rrnd: 0, ev: 0};
        tbl[1] = '{kind: 1, kl: 4,  xv: 0,   wv: 0,    vtog: 1, rrnd: 1, ev: 0};
        tbl[2] = '{kind: 0, kl: 8,  xv: 127, wv: 127,  vtog: 0, rrnd: 0, ev: 127};
        tbl[3] = '{kind: 0, kl: 8,  xv: 127, wv: -128, vtog: 0, rrnd: 1, ev: -128};
        tbl[4] = '{kind: 0, kl: 1,  xv: 32,  wv: -48,  vtog: 0, rrnd: 0, ev: -48};
        tbl[5] = '{kind: 0, kl: 1,  xv: 1,   wv: 16,   vtog: 0, rrnd: 0, ev: 1};
        tbl[6] = '{kind: 0, kl: 1,  xv: 1,   wv: 15,   vtog: 0, rrnd: 0, ev: 0};
        tbl[7] = '{kind: 0, kl: 2,  xv: 1,   wv: -8,   vtog: 1, rrnd: 0, ev: 0};
        tbl[8] = '{kind: 0, kl: 64, xv: 1,   wv: 1,    vtog: 0, rrnd: 0, ev: 2};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 0, 64'(all_out()), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 0, 64'(all_out()), 64'd0);

        for (int n = 0; n < 9; n++) begin
            logic [0:C-1][7:0] er;
            if (tbl[n].kind == 1) load_ident();
            else load_uniform(tbl[n].xv, tbl[n].wv, tbl[n].kl);
            start_feed(tbl[n].kl, 1'b0, 0, tbl[n].vtog, 1'b0);
            drain(tbl[n].rrnd);
            for (int r = 0; r < R; r++) begin
                for (int j = 0; j < C; j++) er[j] = (tbl[n].kind == 1) ? 8'(r + j) : 8'(tbl[n].ev);
                chk($sformatf("vec%0d_row", n), r, 64'(got[r]), 64'(er));
            end
        end

        // Rejected starts: K_LEN = 0 and K_LEN = K_MAX+1.
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            start = 1'b1;
            k_len = (e == 0) ? 7'd0 : 7'd65;
            @(negedge clk);
            start = 1'b0;
            k_len = '0;
            chk("err_pulse_busy_rdy", e, 64'({err, busy, in_rdy}), 64'b100);
            @(negedge clk);
            chk("err_clears_idle", e, 64'({err, busy, in_rdy}), 64'd0);
        end

        // Tiling: two K=4 passes (second accumulating) against one K=8 pass.
        load_mix();
        start_feed(4, 1'b0, 0, 1'b0, 1'b0);
        drain(1'b0);
        for (int r = 0; r < R; r++) chk("tile_a_row", r, 64'(got[r]), 64'(model_row(r, 0, 4)));
        start_feed(4, 1'b1, 4, 1'b1, 1'b1);
        drain(1'b1);
        for (int r = 0; r < R; r++) chk("tile_ab_row", r, 64'(got[r]), 64'(model_row(r, 0, 8)));
        start_feed(8, 1'b0, 0, 1'b0, 1'b0);
        drain(1'b0);
        for (int r = 0; r < R; r++) chk("single_k8_row", r, 64'(got[r]), 64'(model_row(r, 0, 8)));

        // Reset in FLUSH: abort, no DONE, and the next accumulating pass starts from zero.
        begin
            bit done_seen;
            load_uniform(100, 100, 4);
            start_feed(4, 1'b0, 0, 1'b0, 1'b0);
            @(negedge clk);
            @(negedge clk);
            chk("in_flush_busy_vld", 0, 64'({busy, out_vld, in_rdy}), 64'b100);
            #2 rst = 1'b1;
            @(negedge clk);
            chk("rst_flush_outputs", 0, 64'(all_out()), 64'd0);
            rst = 1'b0;
            done_seen = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done || busy) done_seen = 1'b1;
            end
            chk("no_done_after_abort", 0, 64'(done_seen), 64'd0);
            load_uniform(1, 16, 1);
            start_feed(1, 1'b1, 0, 1'b0, 1'b0);
            drain(1'b0);
            for (int r = 0; r < R; r++) chk("post_reset_acc_row", r, 64'(got[r]), 64'h01010101);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_stream_array.md
# sa_stream_array

Parametrised, streaming successor of the team's fixed-size systolic matrix-multiply wrapper. It computes C = X·W for an SA_R×K by K×SA_C tile on an output-stationary PE grid. Operands are streamed one K-slice per beat with valid/ready handshakes. Internally it provides the row/column skew, a K-length runtime register, an accumulate-across-tiles mode, and requantisation with saturation. Results drain back out as one C row per beat with valid/ready. It sits between the MHA operand buffers and the softmax/output stages.

## Interface
- D_W, 8: operand/result width, signed two's complement
- FRAC, 5: fraction bits of operands and result
- ACC_W, 24: accumulator width; must be ≥ 2*D_W + clog2(K_MAX)
- SA_R, 16: array rows (rows of X / C)
- SA_C, 16: array columns (columns of W / C)
- K_MAX, 64: maximum inner dimension per pass
- I_CLK  in  1  sole clock, rising edge
- I_RST  in  1  reset, asynchronous, active-high
- I_START  in  1  start a pass; sampled only in IDLE
- I_K_LEN  in  clog2(K_MAX+1)  inner dimension for this pass, sampled with I_START
- I_ACC_MODE  in  1  sampled with I_START; 1 = keep accumulators from previous pass, 0 = clear
- I_IN_VLD  in  1  operand beat valid
- O_IN_RDY  out  1  operand beat ready
- I_X_COL  in  [D_W-1:0][0:SA_R-1]  column k of X
- I_W_ROW  in  [D_W-1:0][0:SA_C-1]  row k of W
- O_OUT_VLD  out  1  result row valid
- I_OUT_RDY  in  1  result row ready
- O_OUT_ROW  out  [D_W-1:0][0:SA_C-1]  requantised row r of C
- O_OUT_IDX  out  clog2(SA_R)  row index r
- O_BUSY  out  1  state ≠ IDLE
- O_DONE  out  1  one-cycle pulse after the last row handshake
- O_ERR  out  1  one-cycle pulse on a rejected start

## Operation
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - I_START with 1 ≤ I_K_LEN ≤ K_MAX → latch K_LEN and ACC_MODE; if ACC_MODE=0 clear all accumulators; go to FEED.
  - I_START with I_K_LEN=0 or I_K_LEN>K_MAX → O_ERR pulse, stay IDLE, accumulators untouched.
- FEED:
  - O_IN_RDY=1; each vld&rdy beat is one K-slice, beat counter +1.
  - After the K_LEN-th accepted beat → FLUSH; O_IN_RDY drops the next cycle.
- Skew:
  - X element i is delayed i cycles; W element j is delayed j cycles.
  - A valid tag travels with the data. Non-accepted cycles inject tag=0 bubbles, and bubbles never accumulate.
- PE(i,j): on tag=1, acc += sign-extend(x·w), where the product is 2*D_W signed; accumulation wraps modulo 2^ACC_W.
- FLUSH: counter runs SA_R+SA_C-1 cycles, then DRAIN with r=0.
- DRAIN:
  - O_OUT_ROW[j] = sat_D_W((acc[r][j] + 2^(FRAC-1)) >>> FRAC), i.e. round half-up, then saturate to [-2^(D_W-1), 2^(D_W-1)-1].
  - Row advances on vld&rdy. After row SA_R-1 is accepted: O_DONE pulse, then IDLE.
- Accumulators hold their values in IDLE, which is what enables ACC_MODE=1 on the next pass.
- I_START outside IDLE is ignored (no O_ERR).

## Timing
- Reset values:
  - O_IN_RDY, O_OUT_VLD, O_BUSY, O_DONE, O_ERR = 0.
  - O_OUT_ROW, O_OUT_IDX = 0.
  - State IDLE; accumulators and skew registers 0.
- Reset asserted mid-pass: immediate abort, no O_DONE; partial accumulators are cleared.
- Start: accepted start at edge E → O_BUSY=1 and O_IN_RDY=1 from cycle E+1.
- Skew timing: the beat accepted at edge E0 updates PE(i,j) at edge E0+i+j+1.
- Last beat to first output: if the last beat is accepted at edge E0, O_OUT_VLD=1 starting at cycle E0+SA_R+SA_C.
- Output stability: O_OUT_ROW and O_OUT_IDX stay stable while O_OUT_VLD=1 and I_OUT_RDY=0.
- Throughput:
  - With I_OUT_RDY held high, one row per cycle; O_DONE fires the cycle after the row SA_R-1 handshake, with O_BUSY=0 in the same cycle.
  - With I_IN_VLD held high, K_LEN beats take exactly K_LEN cycles.

## Structure
- Shared package sa_pkg holds:
  - state enum sa_state_e;
  - function sa_requant(acc, FRAC, D_W) implementing round-and-saturate;
  - localparam helpers for counter widths.
- Sub-module sa_mac_pe (one PE: tagged x/w pass-through registers, MAC accumulator, clear/hold control), instantiated SA_R×SA_C by generate.
- Skew delay lines, FSM, counters and drain mux live in the top module.

## Test plan
- Identity check: SA_R=SA_C=4, K_LEN=4, X=I·32, W(k,j)=k+j:
  - C row r equals W row r; rows come out in order r=0..3 with O_OUT_IDX=r.
  - First O_OUT_VLD at E0+8.
- Bubbles and backpressure:
  - I_IN_VLD toggling 1010… gives results identical to back-to-back input.
  - Random I_OUT_RDY: each row is held stable and accepted exactly once.
- Saturation and rounding, all x=w=127, K_LEN=8 → every output 127.
- Rounding, x=32, w=-48, K_LEN=1: -1536>>>5 = -48, output -48.
- Rounding, x=1, w=16, K_LEN=1: (16+16)>>>5 = 1, output 1.
- Tiling: pass A (ACC_MODE=0, K_LEN=4) followed by pass B (ACC_MODE=1, K_LEN=4) equals a single K_LEN=8 pass over the concatenated operands.
- Errors and reset:
  - I_K_LEN=0 → O_ERR pulse, O_BUSY stays 0.
  - I_K_LEN=K_MAX+1 → O_ERR pulse, O_BUSY stays 0.
  - I_RST during FLUSH → all outputs 0 next cycle, no O_DONE; a following ACC_MODE=1 pass starts from zero accumulators.
